// File: rtl/mmio_arbiter_pkg.sv
// Shared types and constants for the MMIO slot bus and the arbiters that drive it.
package mmio_pkg;

  localparam int MMIO_DATA_W     = 32;
  localparam int MMIO_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mmio_arbiter_if.sv
// MMIO slot bus: one registered cycle from the arbiter, combinational read data back.
interface mmio_arbiter_if
  import mmio_pkg::*;
#(
  parameter int ADDR_W = 6 + MMIO_REG_ADDR_W
);

  logic                   mmio_cs;
  logic                   mmio_write;
  logic                   mmio_read;
  logic [ADDR_W-1:0]      mmio_addr;
  logic [MMIO_DATA_W-1:0] mmio_wdata;
  logic [MMIO_DATA_W-1:0] mmio_rdata;

  modport master (
    output mmio_cs, mmio_write, mmio_read, mmio_addr, mmio_wdata,
    input  mmio_rdata
  );

  modport slave (
    input  mmio_cs, mmio_write, mmio_read, mmio_addr, mmio_wdata,
    output mmio_rdata
  );

endinterface

// File: rtl/mmio_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path with no assignment infers a latch.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    cand        = '0;
    for (int i = 1; i <= N; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      cand = sum[IDX_W-1:0];
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one MMIO slot bus between N masters; 3-cycle
// IDLE -> ISSUE -> ACK transaction with fully registered outputs.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 6 + MMIO_REG_ADDR_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_MASTERS-1:0]             m_req,
  input  logic [N_MASTERS-1:0]             m_write,
  input  logic [N_MASTERS*ADDR_W-1:0]      m_addr,
  input  logic [N_MASTERS*MMIO_DATA_W-1:0] m_wdata,
  output logic [N_MASTERS-1:0]             m_ack,
  output logic [MMIO_DATA_W-1:0]           m_rdata,
  mmio_arbiter_if.master                   bus
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_t           state;
  logic [IDX_W-1:0]     last_grant;
  logic [N_MASTERS-1:0] cur_grant;

  logic [N_MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  rr_picker #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req         (m_req),
    .ptr         (last_grant),
    .grant       (pick_grant),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // Requests are only looked at in IDLE; the winner's transaction is copied
  // straight into the bus registers, which then hold until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= IDX_W'(N_MASTERS - 1);
      cur_grant      <= '0;
      m_ack          <= '0;
      m_rdata        <= '0;
      bus.mmio_cs    <= 1'b0;
      bus.mmio_write <= 1'b0;
      bus.mmio_read  <= 1'b0;
      bus.mmio_addr  <= '0;
      bus.mmio_wdata <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state          <= ISSUE;
            last_grant     <= pick_idx;
            cur_grant      <= pick_grant;
            bus.mmio_cs    <= 1'b1;
            bus.mmio_write <= m_write[pick_idx];
            bus.mmio_read  <= ~m_write[pick_idx];
            bus.mmio_addr  <= m_addr[pick_idx*ADDR_W +: ADDR_W];
            bus.mmio_wdata <= m_wdata[pick_idx*MMIO_DATA_W +: MMIO_DATA_W];
          end
        end
        ISSUE: begin
          state          <= ACK;
          bus.mmio_cs    <= 1'b0;
          bus.mmio_write <= 1'b0;
          bus.mmio_read  <= 1'b0;
          m_ack          <= cur_grant;
          if (bus.mmio_read) m_rdata <= bus.mmio_rdata;
        end
        ACK: begin
          state <= IDLE;
          m_ack <= '0;
        end
        default: begin
          state <= IDLE;
          m_ack <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Round-robin arbiter that shares one MMIO slot bus between several bus masters, for example the MCS I/O bridge and a UART debug bridge. Each master raises a held request; the arbiter grants one at a time, drives a single registered bus cycle (cs/read/write/addr/write_data) to the slot decoder, captures the read data, and returns a one-cycle acknowledge. It sits between the masters and the MMIO slot decoder that fans out to peripherals such as the GPO slot.

## Interface
- `N_MASTERS`, default 2: number of requesters (2..8).
- `ADDR_W`, default 11: bus address width (slot index plus 5-bit register address).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `m_req` in N_MASTERS: per-master request level, held until that master's ack.
- `m_write` in N_MASTERS: per-master 1 = write, 0 = read; valid while req is high.
- `m_addr` in N_MASTERS×ADDR_W: packed per-master address.
- `m_wdata` in N_MASTERS×32: packed per-master write data.
- `m_ack` out N_MASTERS: one-hot, one-cycle completion pulse.
- `m_rdata` out 32: read data, valid in the ack cycle and held until the next capture.
- `mmio_cs` out 1: bus cycle strobe.
- `mmio_write` out 1: write strobe.
- `mmio_read` out 1: read strobe.
- `mmio_addr` out ADDR_W: bus address.
- `mmio_wdata` out 32: bus write data.
- `mmio_rdata` in 32: combinational read data from the slot decoder.

## Operation
- **States.**
  - IDLE: if any `m_req` is high, pick the winner and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: always go to ACK.
  - ACK: always go to IDLE.
- **Winner selection (in IDLE).** Search starts at `last_grant+1` mod N_MASTERS. The first master with `m_req` high wins. `last_grant` updates to the winner.
- **Latching.** On the IDLE→ISSUE edge, the winner's write, addr and wdata are latched into registers.
- **Bus drive in ISSUE.**
  - `mmio_cs` = 1.
  - `mmio_write` = latched write.
  - `mmio_read` = not latched write.
  - addr and wdata come from the latched registers.
- **Bus drive outside ISSUE.** cs, read and write are 0. addr and wdata hold their last values.
- **Read capture.** At the end of ISSUE, if the cycle is a read, `mmio_rdata` is captured into `m_rdata`. Writes leave `m_rdata` unchanged.
- **Acknowledge.** In ACK, `m_ack[winner]` = 1. All other bits are 0.
- **Request rules.**
  - Requests are not sampled in ISSUE or ACK.
  - A master must drop req, or present a new transaction, in the cycle after its ack.
  - A req that is still high in the following IDLE cycle is treated as a new request.
- **Fairness.** A deasserted req is never granted. Requests are never buffered.
- **Reset values.**
  - State = IDLE.
  - `last_grant` = N_MASTERS-1, so master 0 has first priority.
  - `m_ack`, `mmio_cs`, `mmio_read`, `mmio_write` = 0.
  - `mmio_addr`, `mmio_wdata`, `m_rdata` = 0.
- **Reset mid-transaction.** The transaction is abandoned and no ack is issued. Masters must re-request.

## Timing
- Req high in IDLE at cycle k → bus strobes in cycle k+1 → `m_ack` in cycle k+2. Minimum transaction time is 3 cycles.
- Back-to-back requests from different masters: one grant every 3 cycles.
- Outputs are all registered; there is no combinational path from `m_req` to `mmio_cs`.
- The slot decoder must return `mmio_rdata` combinationally within the ISSUE cycle.
- Simultaneous requests: resolved by the round-robin pointer. With 2 masters both held high continuously, grants alternate 0,1,0,1.
- A request that arrives during ISSUE or ACK waits for the next IDLE.

## Structure
- A shared package `mmio_pkg` holds:
  - the state enum `arb_state_t` (IDLE, ISSUE, ACK);
  - `MMIO_DATA_W` = 32 and `MMIO_REG_ADDR_W` = 5.
- One natural sub-module: `rr_picker`. It is combinational, takes req and the pointer, and returns a one-hot grant plus its index. It is reusable by other arbiters in the design.

## Test plan
- **Single write.** Master 0 writes addr 0x020 with data 0xDEADBEEF.
  - Required: exactly one cycle of cs=1, write=1, addr=0x020, wdata=0xDEADBEEF.
  - Required: `m_ack`=01 two cycles after req.
- **Single read.** Master 1 reads addr 0x041; stub returns 0x12345678.
  - Required: cs=1, read=1 for one cycle.
  - Required: `m_ack`=10 with `m_rdata`=0x12345678, then held afterwards.
- **Contention.** Both masters hold req continuously for 12 cycles.
  - Required: grants in order 0,1,0,1 with acks at cycles 2, 5, 8, 11.
  - Required: at most one `m_ack` bit high in any cycle.
- **Late request.** Master 1 raises req during master 0's ISSUE cycle.
  - Required: master 1's strobe appears two cycles after master 0's ack.
  - Required: no strobes overlap.
- **Reset during ISSUE.** Assert reset in the ISSUE cycle.
  - Required: all outputs go to 0 immediately and no ack is issued.
  - Required: after release with both reqs high, master 0 is granted first.
- **Idle bus.** No requests for 10 cycles.
  - Required: cs, read, write and ack stay 0; addr and wdata hold their last values.
